instr_stream_loader: RTL and testbench

- Upstream feeder of the instruction memory write port.
- Accepts a byte stream of the WASM binary from the host (valid/ready, with a last flag) and packs bytes into write windows of up to WIN bytes.
- Issues one write per window: we, shift-minus-one count and packed data, matching the memory's write-pointer advance rule.
- Tracks a shadow write pointer and back-pressures the host when the memory ring would overrun unread instructions.

---
 rtl/instr_stream_loader.sv | 170 +++++++++++++++++
 tb/tb_instr_stream_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_loader.sv
// instr_stream_loader: packs a host byte stream (valid/ready/last) into write
// windows of up to WIN bytes for the instruction memory write port. It keeps a
// shadow copy of the memory write pointer and stalls while the ring is full.
// Optional header check enabled by defining INSTR_LOADER_MAGIC_CHECK_EN.
module instr_stream_loader #(
  parameter int WIN         = 4,
  parameter int LOG_WIN     = 2,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WR_PTR_INIT = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  input  logic [ADDR_W-1:0]    rd_ptr,
  output logic                 we,
  output logic [LOG_WIN-1:0]   wr_shift_minusone,
  output logic [WIN*8-1:0]     wr_data,
  output logic [ADDR_W-1:0]    wr_ptr,
  output logic                 load_done,
  input  logic                 clear,
  output logic                 magic_err
);

  typedef enum logic [1:0] {FILL, FLUSH, WAIT_SPACE, DONE} state_e;

  localparam int unsigned PTR_MASK = DEPTH - 1;

  state_e                 state_q, state_d;
  logic [LOG_WIN:0]       cnt_q, cnt_d;
  logic [WIN-1:0][7:0]    win_q, win_d;
  logic                   last_q, last_d;
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                   armed_q;
  logic                   accept;
  logic                   drop;
  logic                   fits;
  logic [ADDR_W-1:0]      space;

  assign accept = s_valid & s_ready;
  // One slot is always held back so a full ring never looks empty to the reader.
  assign space  = (rd_ptr - wr_ptr_q - ADDR_W'(1)) & ADDR_W'(PTR_MASK);
  assign fits   = space >= ADDR_W'(cnt_q);
  assign wr_ptr = wr_ptr_q;

`ifdef INSTR_LOADER_MAGIC_CHECK_EN
  logic [2:0] mcnt_q, mcnt_d;
  logic       merr_q, merr_d;
  logic [7:0] exp_byte;
  logic       bad;

  // Header check: compare the first four bytes, flag short streams too.
  always_comb begin
    case (mcnt_q)
      3'd0:    exp_byte = 8'h00;
      3'd1:    exp_byte = 8'h61;
      3'd2:    exp_byte = 8'h73;
      default: exp_byte = 8'h6D;
    endcase
    bad    = accept && (mcnt_q < 3'd4) &&
             ((s_data != exp_byte) || (s_last && mcnt_q != 3'd3));
    mcnt_d = mcnt_q;
    merr_d = merr_q;
    if (state_q == DONE && clear) begin
      mcnt_d = '0;
      merr_d = 1'b0;
    end else begin
      if (accept && mcnt_q < 3'd4) mcnt_d = mcnt_q + 3'd1;
      if (bad) merr_d = 1'b1;
    end
  end

  // Header check state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt_q <= '0;
      merr_q <= 1'b0;
    end else begin
      mcnt_q <= mcnt_d;
      merr_q <= merr_d;
    end
  end

  // Once the header is bad every byte is swallowed, including the open window.
  assign drop      = merr_q | bad;
  assign magic_err = merr_q;
`else
  assign drop      = 1'b0;
  assign magic_err = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      win_q    <= '0;
      last_q   <= 1'b0;
      wr_ptr_q <= ADDR_W'(WR_PTR_INIT);
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      armed_q  <= 1'b1;
    end
  end

  // Next state: collect bytes, then flush when the ring has room.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (drop) begin
            cnt_d = '0;
            win_d = '0;
            if (s_last) state_d = DONE;
          end else begin
            win_d[cnt_q[LOG_WIN-1:0]] = s_data;
            cnt_d  = cnt_q + (LOG_WIN+1)'(1);
            last_d = s_last;
            if (cnt_q == (LOG_WIN+1)'(WIN-1) || s_last) state_d = FLUSH;
          end
        end
      end
      FLUSH, WAIT_SPACE: begin
        if (fits) begin
          wr_ptr_d = (wr_ptr_q + ADDR_W'(cnt_q)) & ADDR_W'(PTR_MASK);
          cnt_d    = '0;
          win_d    = '0;
          last_d   = 1'b0;
          state_d  = last_q ? DONE : FILL;
        end else begin
          state_d  = WAIT_SPACE;
        end
      end
      DONE: begin
        if (clear) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Outputs: the write beat is combinational in the flush cycle that has room.
  always_comb begin
    s_ready           = armed_q && (state_q == FILL);
    load_done         = (state_q == DONE);
    we                = 1'b0;
    wr_shift_minusone = '0;
    wr_data           = '0;
    if ((state_q == FLUSH || state_q == WAIT_SPACE) && fits) begin
      we                = 1'b1;
      wr_shift_minusone = LOG_WIN'(cnt_q - (LOG_WIN+1)'(1));
      for (int j = 0; j < WIN; j++) begin
        if ((LOG_WIN+1)'(j) < cnt_q) wr_data[j*8 +: 8] = win_q[j];
      end
    end
  end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Bench for instr_stream_loader: randomized byte streams against a window model.
module tb_instr_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  rd_ptr;
  logic        we;
  logic [1:0]  wr_shift_minusone;
  logic [31:0] wr_data;
  logic [7:0]  wr_ptr;
  logic        load_done;
  logic        clear;
  logic        magic_err;

  int n_cmp = 0;
  int n_fail = 0;
  int mdl_ptr = 200;

  logic [7:0]  stim[$];
  logic [41:0] obs_q[$];
  logic [41:0] exp_q[$];

  instr_stream_loader dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .rd_ptr(rd_ptr), .we(we),
    .wr_shift_minusone(wr_shift_minusone), .wr_data(wr_data),
    .wr_ptr(wr_ptr), .load_done(load_done), .clear(clear),
    .magic_err(magic_err)
  );

  always #5 clk = ~clk;

  // Capture every write beat as {data, shift_minus_one, address}.
  always @(negedge clk) begin
    if (we === 1'b1) obs_q.push_back({wr_data, wr_shift_minusone, wr_ptr});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: the stream is cut into WIN-byte windows, lane j = byte j.
  task automatic model_stream();
    for (int k = 0; k < stim.size(); k += 4) begin
      int n;
      logic [31:0] d;
      n = (stim.size() - k < 4) ? stim.size() - k : 4;
      d = '0;
      for (int j = 0; j < n; j++) d = d | (32'(stim[k+j]) << (8*j));
      exp_q.push_back({d, 2'(n-1), 8'(mdl_ptr)});
      mdl_ptr = (mdl_ptr + n) % 256;
    end
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  task automatic send(input bit gaps, input bit end_last, output int acc_n, output int iters);
    bit acc;
    acc_n = 0;
    iters = 0;
    while (acc_n < stim.size() && iters < 4000) begin
      @(negedge clk);
      iters++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = stim[acc_n];
        s_last  = end_last && (acc_n == stim.size() - 1);
      end
      acc = s_valid && s_ready;
      @(posedge clk);
      if (acc) acc_n++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(output int w);
    w = 0;
    while (load_done !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mdl_ptr = 200;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    clear = 1'b0; rd_ptr = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s_ready, we, wr_shift_minusone, wr_data, load_done, magic_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b/%b/%h/%h/%b/%b want=all zero",
               s_ready, we, wr_shift_minusone, wr_data, load_done, magic_err);
    end
    n_cmp++;
    if (wr_ptr !== 8'd200) begin
      n_fail++; $display("FAIL reset_wr_ptr got=%0d want=200", wr_ptr);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_at_release got=%b want=0", s_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_release got=%b want=1", s_ready);
    end
    mdl_ptr = 200;
  endtask

  task automatic test_back_to_back();
    int a, it, w;
    obs_q.delete(); exp_q.delete();
    rd_ptr = 8'd0;
    stim = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h01, 8'h00, 8'h00, 8'h00};
    model_stream();
    send(1'b0, 1'b1, a, it);
    wait_done(w);
    n_cmp++;
    if (it !== 9) begin
      n_fail++; $display("FAIL b2b_cycles got=%0d want=9", it);
    end
    n_cmp++;
    if (w !== 1) begin
      n_fail++; $display("FAIL b2b_done_latency got=%0d want=1", w);
    end
    n_cmp++;
    if (obs_q.size() !== 2) begin
      n_fail++; $display("FAIL b2b_count got=%0d want=2", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== {32'h6D736100, 2'd3, 8'd200}) begin
        n_fail++; $display("FAIL b2b_write0 got=%h want=%h", obs_q[0], {32'h6D736100, 2'd3, 8'd200});
      end
      n_cmp++;
      if (obs_q[1] !== {32'h00000001, 2'd3, 8'd204}) begin
        n_fail++; $display("FAIL b2b_write1 got=%h want=%h", obs_q[1], {32'h00000001, 2'd3, 8'd204});
      end
    end
    n_cmp++;
    if (wr_ptr !== 8'd208 || load_done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_end got=ptr %0d done %b want=ptr 208 done 1", wr_ptr, load_done);
    end
    pulse_clear();
    n_cmp++;
    if (load_done !== 1'b0 || wr_ptr !== 8'd208 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_clear got=done %b ptr %0d ready %b want=0 208 1", load_done, wr_ptr, s_ready);
    end
  endtask

  task automatic test_reset_midwindow();
    int a, it;
    obs_q.delete();
    rd_ptr = 8'd0;
    rand_stim(3);
    send(1'b1, 1'b0, a, it);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({s_ready, we, wr_shift_minusone, wr_data, load_done, magic_err} !== '0 || wr_ptr !== 8'd200) begin
      n_fail++; $display("FAIL midreset_outputs got=ready %b we %b ptr %0d want=0 0 200", s_ready, we, wr_ptr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_fail++; $display("FAIL midreset_no_we got=%0d writes want=0", obs_q.size());
    end
    mdl_ptr = 200;
  endtask

  task automatic test_short_window();
    int a, it, w;
    obs_q.delete(); exp_q.delete();
    rd_ptr = 8'd0;
    rand_stim(6);
    model_stream();
    send(1'b1, 1'b1, a, it);
    wait_done(w);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL short_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL short_write[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (wr_ptr !== 8'd206) begin
      n_fail++; $display("FAIL short_wr_ptr got=%0d want=206", wr_ptr);
    end
    pulse_clear();
  endtask

  task automatic test_random_streams();
    int a, it, w;
    for (int t = 0; t < 12; t++) begin
      obs_q.delete(); exp_q.delete();
      rd_ptr = 8'((mdl_ptr + 128) % 256);
      rand_stim($urandom_range(1, 20));
      model_stream();
      send(1'($urandom), 1'b1, a, it);
      wait_done(w);
      n_cmp++;
      if (w >= 300 || obs_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count got=%0d want=%0d", t, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_write[%0d] got=%h want=%h", t, i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (wr_ptr !== 8'(mdl_ptr) || magic_err !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_end got=ptr %0d err %b want=ptr %0d err 0", t, wr_ptr, magic_err, mdl_ptr);
      end
      pulse_clear();
    end
  endtask

  task automatic test_wrap();
    int a, it, w;
    do_reset();
    rd_ptr = 8'd100;
    rand_stim(52);
    model_stream();
    send(1'b0, 1'b1, a, it);
    wait_done(w);
    pulse_clear();
    obs_q.delete(); exp_q.delete();
    rand_stim(8);
    model_stream();
    send(1'b1, 1'b1, a, it);
    wait_done(w);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL wrap_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_write[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (wr_ptr !== 8'd4) begin
      n_fail++; $display("FAIL wrap_wr_ptr got=%0d want=4", wr_ptr);
    end
    pulse_clear();
  endtask

  task automatic test_wait_space();
    int a, it;
    logic [31:0] d;
    do_reset();
    rd_ptr = 8'd203;
    rand_stim(4);
    model_stream();
    d = exp_q[0][41:10];
    send(1'b0, 1'b1, a, it);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b0 || obs_q.size() !== 0 || load_done !== 1'b0) begin
      n_fail++; $display("FAIL stall got=ready %b writes %0d done %b want=0 0 0", s_ready, obs_q.size(), load_done);
    end
    // clear while not in DONE must have no effect
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #2 rd_ptr = 8'd205;
    #1;
    n_cmp++;
    if (we !== 1'b1 || wr_data !== d || wr_shift_minusone !== 2'd3) begin
      n_fail++; $display("FAIL release_write got=we %b data %h smo %0d want=1 %h 3", we, wr_data, wr_shift_minusone, d);
    end
    @(negedge clk);
    n_cmp++;
    if (wr_ptr !== 8'd204 || load_done !== 1'b1) begin
      n_fail++; $display("FAIL release_end got=ptr %0d done %b want=204 1", wr_ptr, load_done);
    end
    pulse_clear();
  endtask

`ifdef INSTR_LOADER_MAGIC_CHECK_EN
  task automatic test_magic();
    int a, it, w;
    do_reset();
    rd_ptr = 8'd0;
    stim = '{8'h00, 8'h61, 8'h73, 8'h6E, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(1'b1, 1'b1, a, it);
    wait_done(w);
    n_cmp++;
    if (obs_q.size() !== 0 || magic_err !== 1'b1 || load_done !== 1'b1 || a !== 9) begin
      n_fail++; $display("FAIL magic_bad got=writes %0d err %b done %b acc %0d want=0 1 1 9", obs_q.size(), magic_err, load_done, a);
    end
    pulse_clear();
    n_cmp++;
    if (magic_err !== 1'b0 || load_done !== 1'b0) begin
      n_fail++; $display("FAIL magic_clear got=err %b done %b want=0 0", magic_err, load_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_reset_midwindow();
    test_short_window();
    test_random_streams();
    test_wrap();
    test_wait_space();
`ifdef INSTR_LOADER_MAGIC_CHECK_EN
    test_magic();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
